// File: rtl/cb_rd_seq.sv
// Cache-bank port-A read sequencer: issues len address beats per command and delivers a
// select/beat-index tag aligned with the bank's read data RD_LAT cycles later.
module cb_rd_seq #(
  parameter int unsigned L               = 4,
  parameter int unsigned CB_AW           = 10,
  parameter int unsigned SEQ_CNT_DW      = 5,
  parameter int unsigned CB_DOUTA_SEL_DW = 5,
  parameter int unsigned RD_LAT          = 1
) (
  input  logic                       clk,
  input  logic                       sys_rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [2:0]                 cmd_dst,
  input  logic [1:0]                 cmd_dir,
  input  logic [CB_AW-1:0]           cmd_base,
  input  logic [SEQ_CNT_DW-1:0]      cmd_len,
  input  logic                       cmd_dec,
  input  logic                       abort,
  output logic                       CB_ena,
  output logic [CB_AW-1:0]           CB_addra,
  output logic [CB_DOUTA_SEL_DW-1:0] CB_douta_sel,
  output logic [SEQ_CNT_DW-1:0]      seq_cnt_out,
  output logic                       busy,
  output logic                       done
);

  if (RD_LAT < 1 || RD_LAT > 3 || L < 1) begin : g_bad_param
    $error("cb_rd_seq: RD_LAT must be 1..3 and L nonzero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  localparam logic [1:0] DrainLast = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  state_e                state_q;
  logic [2:0]            dst_q;
  logic [1:0]            dir_q;
  logic [SEQ_CNT_DW-1:0] len_q;
  logic                  dec_q;
  logic [SEQ_CNT_DW-1:0] cnt_q;
  logic [1:0]            drain_q;
  logic                  noop_q;
  logic                  noop_done_q;
  logic                  last_beat;

  logic [CB_DOUTA_SEL_DW-1:0] sel_pipe_q [RD_LAT];
  logic [SEQ_CNT_DW-1:0]      cnt_pipe_q [RD_LAT];
  logic [RD_LAT-1:0]          last_pipe_q;

  function automatic logic dst_legal(logic [2:0] d);
    return d inside {3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
  endfunction

  assign last_beat = (cnt_q == len_q - 1'b1);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= StIdle;
      dst_q    <= '0;
      dir_q    <= '0;
      len_q    <= '0;
      dec_q    <= 1'b0;
      cnt_q    <= '0;
      drain_q  <= '0;
      noop_q   <= 1'b0;
      CB_ena   <= 1'b0;
      CB_addra <= '0;
    end else if (abort) begin
      // Cancel wins over everything, including a command offered in the same cycle.
      state_q <= StIdle;
      CB_ena  <= 1'b0;
      noop_q  <= 1'b0;
    end else begin
      noop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            dst_q <= cmd_dst;
            dir_q <= cmd_dir;
            len_q <= cmd_len;
            dec_q <= cmd_dec;
            cnt_q <= '0;
            if (cmd_len != '0 && dst_legal(cmd_dst)) begin
              state_q  <= StIssue;
              CB_ena   <= 1'b1;
              CB_addra <= cmd_base;
            end else begin
              noop_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (last_beat) begin
            CB_ena <= 1'b0;
            if (RD_LAT > 1) begin
              state_q <= StDrain;
              drain_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q    <= cnt_q + 1'b1;
            CB_addra <= dec_q ? CB_addra - 1'b1 : CB_addra + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q == DrainLast) begin
            state_q <= StIdle;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tag pipeline mirrors the bank read latency; empty slots carry zeros.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        sel_pipe_q[i] <= '0;
        cnt_pipe_q[i] <= '0;
      end
      last_pipe_q <= '0;
      noop_done_q <= 1'b0;
    end else if (abort) begin
      for (int i = 0; i < RD_LAT; i++) begin
        sel_pipe_q[i] <= '0;
        cnt_pipe_q[i] <= '0;
      end
      last_pipe_q <= '0;
      noop_done_q <= 1'b0;
    end else begin
      sel_pipe_q[0]  <= CB_ena ? CB_DOUTA_SEL_DW'({dst_q, dir_q}) : '0;
      cnt_pipe_q[0]  <= CB_ena ? cnt_q : '0;
      last_pipe_q[0] <= CB_ena & last_beat;
      for (int i = 1; i < RD_LAT; i++) begin
        sel_pipe_q[i]  <= sel_pipe_q[i-1];
        cnt_pipe_q[i]  <= cnt_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      noop_done_q <= noop_q;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = ~cmd_ready;
  assign CB_douta_sel = sel_pipe_q[RD_LAT-1];
  assign seq_cnt_out  = cnt_pipe_q[RD_LAT-1];
  assign done         = last_pipe_q[RD_LAT-1] | noop_done_q;

endmodule

// File: tb/tb_cb_rd_seq.sv
// Bench for cb_rd_seq: three instances (RD_LAT 1..3) share stimulus; a per-cycle schedule
// model built from the command rules predicts every output.
module tb_cb_rd_seq;

  localparam int NI   = 3;
  localparam int NCYC = 2400;
  localparam int AMSK = 1023;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       cmd_valid;
  logic [2:0] cmd_dst;
  logic [1:0] cmd_dir;
  logic [9:0] cmd_base;
  logic [4:0] cmd_len;
  logic       cmd_dec;
  logic       abort;

  logic       cmd_ready [NI];
  logic       busy      [NI];
  logic       done      [NI];
  logic       ena       [NI];
  logic [9:0] addra     [NI];
  logic [4:0] sel       [NI];
  logic [4:0] cnt       [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cb_rd_seq #(.RD_LAT(g + 1)) u_dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready[g]),
      .cmd_dst      (cmd_dst),
      .cmd_dir      (cmd_dir),
      .cmd_base     (cmd_base),
      .cmd_len      (cmd_len),
      .cmd_dec      (cmd_dec),
      .abort        (abort),
      .CB_ena       (ena[g]),
      .CB_addra     (addra[g]),
      .CB_douta_sel (sel[g]),
      .seq_cnt_out  (cnt[g]),
      .busy         (busy[g]),
      .done         (done[g])
    );
  end

  always #5 clk = ~clk;

  // Expected outputs per absolute cycle; anything not scheduled is zero.
  bit exp_ena  [NI][NCYC];
  int exp_addr [NI][NCYC];
  int exp_sel  [NI][NCYC];
  int exp_cnt  [NI][NCYC];
  bit exp_done [NI][NCYC];
  int busy_end [NI];
  int held     [NI];
  int cyc;
  int n_checks;
  int n_pass;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
  endtask

  task automatic check_cycle();
    for (int i = 0; i < NI; i++) begin
      int rdy;
      if (exp_ena[i][cyc]) held[i] = exp_addr[i][cyc];
      rdy = (cyc > busy_end[i]) ? 1 : 0;
      check($sformatf("lat%0d ena", i + 1), int'(ena[i]), int'(exp_ena[i][cyc]));
      check($sformatf("lat%0d addr", i + 1), int'(addra[i]), held[i]);
      check($sformatf("lat%0d sel", i + 1), int'(sel[i]), exp_sel[i][cyc]);
      check($sformatf("lat%0d seq_cnt", i + 1), int'(cnt[i]), exp_cnt[i][cyc]);
      check($sformatf("lat%0d done", i + 1), int'(done[i]), int'(exp_done[i][cyc]));
      check($sformatf("lat%0d ready", i + 1), int'(cmd_ready[i]), rdy);
      check($sformatf("lat%0d busy", i + 1), int'(busy[i]), 1 - rdy);
    end
  endtask

  task automatic check_zero(input string what);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s lat%0d ena", what, i + 1), int'(ena[i]), 0);
      check($sformatf("%s lat%0d addr", what, i + 1), int'(addra[i]), 0);
      check($sformatf("%s lat%0d sel", what, i + 1), int'(sel[i]), 0);
      check($sformatf("%s lat%0d seq_cnt", what, i + 1), int'(cnt[i]), 0);
      check($sformatf("%s lat%0d done", what, i + 1), int'(done[i]), 0);
      check($sformatf("%s lat%0d busy", what, i + 1), int'(busy[i]), 0);
      check($sformatf("%s lat%0d ready", what, i + 1), int'(cmd_ready[i]), 1);
    end
  endtask

  task automatic clear_future(input int i);
    for (int x = cyc + 1; x <= cyc + 40 && x < NCYC; x++) begin
      exp_ena[i][x]  = 1'b0;
      exp_sel[i][x]  = 0;
      exp_cnt[i][x]  = 0;
      exp_done[i][x] = 1'b0;
    end
    if (busy_end[i] > cyc) busy_end[i] = cyc;
  endtask

  // Schedule consequences of the edge that ends the current cycle.
  task automatic model_edge(input bit v, input logic [2:0] dst, input logic [1:0] dir,
                            input int base, input int len, input bit dec, input bit ab);
    for (int i = 0; i < NI; i++) begin
      int lat;
      lat = i + 1;
      if (ab) begin
        clear_future(i);
      end else if (v && cyc > busy_end[i]) begin
        if (len == 0 || dst inside {3'd0, 3'd5, 3'd6}) begin
          if (cyc + 2 < NCYC) exp_done[i][cyc + 2] = 1'b1;
        end else begin
          for (int k = 0; k < len; k++) begin
            int t;
            t = cyc + 1 + k;
            if (t + lat < NCYC) begin
              exp_ena[i][t]        = 1'b1;
              exp_addr[i][t]       = (dec ? base - k : base + k) & AMSK;
              exp_sel[i][t + lat]  = int'(dst) * 4 + int'(dir);
              exp_cnt[i][t + lat]  = k;
            end
          end
          if (cyc + len + lat < NCYC) exp_done[i][cyc + len + lat] = 1'b1;
          busy_end[i] = cyc + len + lat - 1;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [2:0] dst, input logic [1:0] dir,
                      input int base, input int len, input bit dec, input bit ab);
    @(posedge clk);
    #1;
    check_cycle();
    cmd_valid = v;
    cmd_dst   = dst;
    cmd_dir   = dir;
    cmd_base  = 10'(base);
    cmd_len   = 5'(len);
    cmd_dec   = dec;
    abort     = ab;
    model_edge(v, dst, dir, base, len, dec, ab);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 3'd0, 2'd0, 0, 0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse raised mid-cycle and released mid-cycle one edge later.
  task automatic rst_mid();
    @(posedge clk);
    #1;
    check_cycle();
    cmd_valid = 1'b0;
    abort     = 1'b0;
    #2;
    sys_rst = 1'b1;
    #1;
    check_zero("async rst");
    for (int i = 0; i < NI; i++) begin
      clear_future(i);
      held[i] = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
    check_cycle();
    #1;
    sys_rst = 1'b0;
    cyc++;
  endtask

  initial begin
    sys_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_dst   = '0;
    cmd_dir   = '0;
    cmd_base  = '0;
    cmd_len   = '0;
    cmd_dec   = 1'b0;
    abort     = 1'b0;
    cyc       = 0;
    n_checks  = 0;
    n_pass    = 0;
    for (int i = 0; i < NI; i++) begin
      busy_end[i] = -1;
      held[i]     = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #3;
    sys_rst = 1'b0;

    step(1'b1, 3'b001, 2'b01, 10, 4, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 3'b100, 2'b11, 2, 5, 1'b1, 1'b0);
    idle(10);
    step(1'b1, 3'b001, 2'b01, 50, 0, 1'b0, 1'b0);
    idle(4);
    step(1'b1, 3'b101, 2'b10, 60, 4, 1'b0, 1'b0);
    idle(4);
    // Abort in cycle 2 of a len-8 command, new command offered in cycle 3.
    step(1'b1, 3'b001, 2'b10, 100, 8, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 3'd0, 2'd0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 3'b011, 2'b01, 200, 2, 1'b1, 1'b0);
    idle(10);
    for (int j = 0; j < 20; j++) step(1'b1, 3'b010, 2'b01, 500, 3, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 3'b001, 2'b01, 300, 10, 1'b0, 1'b0);
    idle(3);
    rst_mid();
    step(1'b1, 3'b011, 2'b10, 7, 3, 1'b1, 1'b0);
    idle(8);

    for (int j = 0; j < 1500; j++) begin
      bit         v;
      bit         ab;
      logic [2:0] dst;
      int         len;
      v   = ($urandom % 4) != 0;
      ab  = ($urandom % 50) == 0;
      dst = 3'($urandom);
      len = (($urandom % 8) == 0) ? int'($urandom_range(9, 31)) : int'($urandom_range(0, 8));
      step(v, dst, 2'($urandom), int'($urandom_range(0, 1023)), len, bit'($urandom % 2), ab);
    end
    idle(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
